// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB bus arbiter.
// State encoding and the timeout read-data marker live here.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_arb_rr_pick.sv
// Combinational round-robin picker.
// Search starts one past rr_last and wraps modulo NUM_REQ.
module apb_arb_rr_pick #(
  parameter int NUM_REQ = 2,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_last,
  output logic [IDW-1:0]     winner,
  output logic               any_req
);

  always_comb begin
    int idx;
    idx     = 0;
    winner  = '0;
    any_req = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_last) + k) % NUM_REQ;
      if (!any_req && req[idx[IDW-1:0]]) begin
        any_req = 1'b1;
        winner  = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_bus_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters.
// Define ARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES with an err pulse.
module apb_bus_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req_transfer,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      m_transfer,
  output logic                      m_write,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_wdata,
  input  logic                      m_ready,
  input  logic [DATA_W-1:0]         m_rdata,
  output logic [IDW-1:0]            grant_id,
  output logic                      busy,
  output logic                      err
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("apb_bus_arbiter: bad NUM_REQ or TIMEOUT_CYCLES");
  end

  arb_state_e         state;
  logic [IDW-1:0]     rr_last;
  logic [IDW-1:0]     win;
  logic               any_req;
  logic               to_hit;
  logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  apb_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (req_transfer),
    .rr_last (rr_last),
    .winner  (win),
    .any_req (any_req)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;
  logic          err_q;

  always_ff @(posedge PCLK) begin
    if (!PRESET || state != WAIT) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Fires in the last permitted WAIT cycle if the slave is still silent.
  assign to_hit = (state == WAIT) && !m_ready &&
                  (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      err_q <= 1'b0;
    end else begin
      err_q <= to_hit;
    end
  end

  assign err = err_q;
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state      <= IDLE;
      m_transfer <= 1'b0;
      m_write    <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      req_ready  <= '0;
      req_rdata  <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      rr_last    <= IDW'(NUM_REQ - 1);
    end else begin
      m_transfer <= 1'b0;
      req_ready  <= '0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            m_write    <= req_write[win];
            m_addr     <= addr_a[win];
            m_wdata    <= wdata_a[win];
            grant_id   <= win;
            m_transfer <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (m_ready) begin
            req_rdata            <= m_write ? '0 : m_rdata;
            req_ready[grant_id]  <= 1'b1;
            state                <= RESP;
          end else if (to_hit) begin
            req_rdata            <= DATA_W'(ERR_RDATA);
            req_ready[grant_id]  <= 1'b1;
            state                <= RESP;
          end
        end
        RESP: begin
          rr_last <= grant_id;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Directed testbench for apb_bus_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8).
// Honours ARB_TIMEOUT_EN for the timeout scenario.
module tb_apb_bus_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b0;
  logic [1:0]  req_transfer = '0;
  logic [1:0]  req_write = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  req_ready;
  logic [31:0] req_rdata;
  logic        m_transfer;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        grant_id;
  logic        busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  int mt_cnt  = 0;

  apb_bus_arbiter #(
    .NUM_REQ        (2),
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .req_transfer (req_transfer),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .req_rdata    (req_rdata),
    .m_transfer   (m_transfer),
    .m_write      (m_write),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_ready      (m_ready),
    .m_rdata      (m_rdata),
    .grant_id     (grant_id),
    .busy         (busy),
    .err          (err)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (m_transfer) mt_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (!m_transfer && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_issue"}, 64'(m_transfer), 64'd1);
  endtask

  // Call in ISSUE; returns in RESP. extra = idle WAIT cycles before m_ready.
  task automatic complete(input int extra, input logic [31:0] rd);
    tick();
    repeat (extra) tick();
    m_ready = 1'b1;
    m_rdata = rd;
    tick();
    m_ready = 1'b0;
    m_rdata = '0;
  endtask

  initial begin
    int mt0;
    int n;

    // reset state
    PRESET = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mt", 64'(m_transfer), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rdata", 64'(req_rdata), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    PRESET = 1'b1;
    tick();

    // 1: single read
    mt0 = mt_cnt;
    req_addr[31:0] = 32'h1000_0004;
    req_write = 2'b00;
    req_transfer = 2'b01;
    wait_issue("t1");
    chk("t1_addr", 64'(m_addr), 64'h1000_0004);
    chk("t1_wr", 64'(m_write), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_gid", 64'(grant_id), 64'd0);
    complete(1, 32'h0000_00A5);
    chk("t1_ready", 64'(req_ready), 64'd1);
    chk("t1_rdata", 64'(req_rdata), 64'hA5);
    req_transfer = 2'b00;
    tick();
    chk("t1_ready_off", 64'(req_ready), 64'd0);
    chk("t1_busy_off", 64'(busy), 64'd0);
    chk("t1_mt_cnt", 64'(mt_cnt - mt0), 64'd1);

    // 2: contention from reset
    PRESET = 1'b0;
    tick();
    PRESET = 1'b1;
    req_addr[31:0]  = 32'h2000_0000;
    req_addr[63:32] = 32'h2000_0100;
    req_transfer = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_issue("t2");
      chk("t2_gid", 64'(grant_id), 64'(i % 2));
      chk("t2_addr", 64'(m_addr),
          (i % 2 == 0) ? 64'h2000_0000 : 64'h2000_0100);
      complete(0, 32'h100 + 32'(i));
      chk("t2_ready", 64'(req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("t2_rdata", 64'(req_rdata), 64'h100 + 64'(i));
    end
    req_transfer = 2'b00;
    tick();

    // 3: write passthrough, fields latched
    req_addr[63:32]  = 32'h1000_1000;
    req_wdata[63:32] = 32'h0000_00FF;
    req_write = 2'b10;
    req_transfer = 2'b10;
    wait_issue("t3");
    chk("t3_gid", 64'(grant_id), 64'd1);
    chk("t3_wr", 64'(m_write), 64'd1);
    chk("t3_addr", 64'(m_addr), 64'h1000_1000);
    chk("t3_wdata", 64'(m_wdata), 64'hFF);
    tick();
    req_wdata[63:32] = 32'h0000_1234;
    req_addr[63:32]  = 32'h0;
    tick();
    chk("t3_wdata_hold", 64'(m_wdata), 64'hFF);
    chk("t3_addr_hold", 64'(m_addr), 64'h1000_1000);
    chk("t3_wr_hold", 64'(m_write), 64'd1);
    m_ready = 1'b1;
    m_rdata = 32'h5A5A;
    tick();
    m_ready = 1'b0;
    chk("t3_ready", 64'(req_ready), 64'd2);
    chk("t3_rdata_zero", 64'(req_rdata), 64'd0);
    req_transfer = 2'b00;
    req_write = 2'b00;
    tick();

    // 4: back-to-back on req0
    req_addr[31:0] = 32'h1000_0010;
    req_transfer = 2'b01;
    wait_issue("t4");
    for (int k = 0; k < 3; k++) begin
      complete(0, 32'(k));
      chk("t4_ready", 64'(req_ready), 64'd1);
      tick();
      chk("t4_gap", 64'(m_transfer), 64'd0);
      tick();
      chk("t4_reissue", 64'(m_transfer), 64'd1);
    end
    req_transfer = 2'b00;
    complete(0, 32'h0);
    tick();

    // 5: reset mid-WAIT restores req0 priority
    req_transfer = 2'b11;
    wait_issue("t5a");
    chk("t5_gid_pre", 64'(grant_id), 64'd1);
    tick();
    PRESET = 1'b0;
    tick();
    PRESET = 1'b1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_no_ready", 64'(req_ready), 64'd0);
    chk("t5_gid_rst", 64'(grant_id), 64'd0);
    wait_issue("t5b");
    chk("t5_gid_post", 64'(grant_id), 64'd0);
    complete(0, 32'h77);
    chk("t5_ready", 64'(req_ready), 64'd1);
    req_transfer = 2'b00;
    tick();

    // 6: slave never answers
    req_addr[31:0] = 32'h1000_0020;
    req_transfer = 2'b01;
    wait_issue("t6");
`ifdef ARB_TIMEOUT_EN
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    chk("t6_latency", 64'(n), 64'd9);
    chk("t6_ready", 64'(req_ready), 64'd1);
    chk("t6_err", 64'(err), 64'd1);
    chk("t6_rdata", 64'(req_rdata), 64'hDEAD_BEEF);
    req_transfer = 2'b00;
    tick();
    chk("t6_err_off", 64'(err), 64'd0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tick();
    chk("t6_late_busy", 64'(busy), 64'd0);
    chk("t6_late_ready", 64'(req_ready), 64'd0);
`else
    n = 0;
    repeat (30) begin
      tick();
      if (req_ready != 2'b00) n++;
    end
    chk("t6_busy", 64'(busy), 64'd1);
    chk("t6_no_ready", 64'(n), 64'd0);
    chk("t6_err", 64'(err), 64'd0);
    req_transfer = 2'b00;
    PRESET = 1'b0;
    tick();
    PRESET = 1'b1;
    tick();
    chk("t6_busy_rst", 64'(busy), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
